// File: rtl/fallthrough_commit_fifo.sv
// fallthrough_commit_fifo
//   First-word-fallthrough FIFO with optional packet commit/drop, occupancy
//   outputs and sticky overflow/underflow flags. Writes to a full FIFO and
//   reads from an empty FIFO are rejected and leave the pointers untouched.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset (clears pointers and flags)
//   din          write data
//   wr_en        write request, accepted when not full
//   wr_commit    publish all uncommitted words, incl. one written this cycle
//   wr_drop      discard all uncommitted words, incl. one written this cycle
//   rd_en        pop head word, accepted when not empty
//   dout         head word, valid whenever empty = 0
//   empty        no committed words available
//   full         used == depth
//   nearly_full  used >= NEARLY_FULL
//   count        committed words available to the reader
//   used         total words held (committed + uncommitted)
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module fallthrough_commit_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1,
  parameter int COMMIT_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    wr_commit,
  input  logic                    wr_drop,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic                    nearly_full,
  output logic [MAX_DEPTH_BITS:0] count,
  output logic [MAX_DEPTH_BITS:0] used,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam int PW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] cm_ptr_reg, cm_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] wr_ptr_inc;
  logic          overflow_reg, underflow_reg;
  logic [PW-1:0] used_w, count_w;
  logic          full_w, empty_w;
  logic          wr_accept, rd_accept;

  // The extra pointer bit distinguishes full from empty; differences wrap
  // naturally in PW bits.
  assign used_w  = wr_ptr_reg - rd_ptr_reg;
  assign count_w = cm_ptr_reg - rd_ptr_reg;
  assign full_w  = (used_w == PW'(DEPTH));
  assign empty_w = (count_w == '0);

  // Acceptance uses the pre-edge flags only: a read in the same cycle never
  // frees room for a write, and a write never feeds a same-cycle read.
  assign wr_accept = wr_en & ~full_w;
  assign rd_accept = rd_en & ~empty_w;

  assign wr_ptr_inc  = wr_ptr_reg + PW'(wr_accept);
  assign rd_ptr_next = rd_ptr_reg + PW'(rd_accept);

  generate
    if (COMMIT_MODE != 0) begin : g_commit
      // Drop rewinds the writer to the last commit point; any word written
      // this cycle lands beyond cm_ptr and is therefore discarded with it.
      always_comb begin
        wr_ptr_next = wr_ptr_inc;
        cm_ptr_next = cm_ptr_reg;
        if (wr_drop) begin
          wr_ptr_next = cm_ptr_reg;
        end else if (wr_commit) begin
          cm_ptr_next = wr_ptr_inc;
        end
      end
    end else begin : g_plain
      // Every accepted word is published immediately; commit/drop unused.
      logic unused_ctrl;
      assign unused_ctrl = wr_commit ^ wr_drop;
      always_comb begin
        wr_ptr_next = wr_ptr_inc;
        cm_ptr_next = wr_ptr_inc;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      cm_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      cm_ptr_reg    <= cm_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      overflow_reg  <= overflow_reg  | (wr_en & full_w);
      underflow_reg <= underflow_reg | (rd_en & empty_w);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[MAX_DEPTH_BITS-1:0]] <= din;
    end
  end

  // Fallthrough: head word read combinationally so it is visible the cycle
  // after it becomes committed, with no bubble between consecutive reads.
  assign dout        = mem[rd_ptr_reg[MAX_DEPTH_BITS-1:0]];
  assign empty       = empty_w;
  assign full        = full_w;
  assign nearly_full = (32'(used_w) >= 32'(NEARLY_FULL));
  assign count       = count_w;
  assign used        = used_w;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_fallthrough_commit_fifo.sv
// Testbench for fallthrough_commit_fifo: one instance in plain mode and one
// in commit mode share the same stimulus. A queue-based model (one queue for
// mode 0; committed + pending queues for mode 1) is checked every cycle, and
// directed phases add literal expectations.
module tb_fallthrough_commit_fifo;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0, wr_commit = 1'b0, wr_drop = 1'b0, rd_en = 1'b0;

  logic [W-1:0] o0_dout, o1_dout;
  logic         o0_empty, o0_full, o0_nearly_full, o0_overflow, o0_underflow;
  logic         o1_empty, o1_full, o1_nearly_full, o1_overflow, o1_underflow;
  logic [3:0]   o0_count, o0_used, o1_count, o1_used;

  fallthrough_commit_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(3), .COMMIT_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .wr_commit(wr_commit),
    .wr_drop(wr_drop), .rd_en(rd_en), .dout(o0_dout), .empty(o0_empty),
    .full(o0_full), .nearly_full(o0_nearly_full), .count(o0_count),
    .used(o0_used), .overflow(o0_overflow), .underflow(o0_underflow));

  fallthrough_commit_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(3), .COMMIT_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .wr_commit(wr_commit),
    .wr_drop(wr_drop), .rd_en(rd_en), .dout(o1_dout), .empty(o1_empty),
    .full(o1_full), .nearly_full(o1_nearly_full), .count(o1_count),
    .used(o1_used), .overflow(o1_overflow), .underflow(o1_underflow));

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  // Reference state: words in FIFO order.
  logic [W-1:0] q0[$];          // mode 0: everything is visible
  logic [W-1:0] c1[$], u1[$];   // mode 1: committed / pending words
  bit of0, uf0, of1, uf1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_update();
    bit w, r;
    if (reset) begin
      q0.delete(); c1.delete(); u1.delete();
      of0 = 0; uf0 = 0; of1 = 0; uf1 = 0;
      started = 1;
      return;
    end
    w = wr_en && (q0.size() < D);
    r = rd_en && (q0.size() > 0);
    if (wr_en && !w) of0 = 1;
    if (rd_en && !r) uf0 = 1;
    if (r) void'(q0.pop_front());
    if (w) q0.push_back(din);

    w = wr_en && ((c1.size() + u1.size()) < D);
    r = rd_en && (c1.size() > 0);
    if (wr_en && !w) of1 = 1;
    if (rd_en && !r) uf1 = 1;
    if (r) void'(c1.pop_front());
    if (w) u1.push_back(din);
    if (wr_drop) begin
      u1.delete();
    end else if (wr_commit) begin
      foreach (u1[i]) c1.push_back(u1[i]);
      u1.delete();
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [W-1:0] d,
                      input bit wc, input bit wd, input bit re);
    reset = rst; wr_en = we; din = d; wr_commit = wc; wr_drop = wd; rd_en = re;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m0_empty", int'(o0_empty), int'(q0.size() == 0));
      chk("m0_full", int'(o0_full), int'(q0.size() == D));
      chk("m0_nfull", int'(o0_nearly_full), int'(q0.size() >= D - 1));
      chk("m0_count", int'(o0_count), q0.size());
      chk("m0_used", int'(o0_used), q0.size());
      chk("m0_ovf", int'(o0_overflow), int'(of0));
      chk("m0_udf", int'(o0_underflow), int'(uf0));
      if (q0.size() > 0) chk("m0_dout", int'(o0_dout), int'(q0[0]));
      chk("m1_empty", int'(o1_empty), int'(c1.size() == 0));
      chk("m1_full", int'(o1_full), int'(c1.size() + u1.size() == D));
      chk("m1_nfull", int'(o1_nearly_full), int'(c1.size() + u1.size() >= D - 1));
      chk("m1_count", int'(o1_count), c1.size());
      chk("m1_used", int'(o1_used), c1.size() + u1.size());
      chk("m1_ovf", int'(o1_overflow), int'(of1));
      chk("m1_udf", int'(o1_underflow), int'(uf1));
      if (c1.size() > 0) chk("m1_dout", int'(o1_dout), int'(c1[0]));
    end
  end

  initial begin
    // Reset state
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    @(negedge clk);
    chk("rst_empty", int'(o0_empty), 1);
    chk("rst_full", int'(o0_full), 0);
    chk("rst_nfull", int'(o0_nearly_full), 0);
    chk("rst_count", int'(o0_count), 0);
    chk("rst_used", int'(o0_used), 0);

    // 1: single word fallthrough and pop
    step(0, 1, 16'h0011, 0, 0, 0);
    @(negedge clk);
    chk("t1_empty", int'(o0_empty), 0);
    chk("t1_dout", int'(o0_dout), 'h11);
    chk("t1_count", int'(o0_count), 1);
    chk("t1_used", int'(o0_used), 1);
    step(0, 0, '0, 0, 0, 1);
    @(negedge clk);
    chk("t1_empty_after_rd", int'(o0_empty), 1);
    chk("t1_count_after_rd", int'(o0_count), 0);

    // 2: fill, overflow, drain without bubbles
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < D; i++) begin
      step(0, 1, W'(i), 0, 0, 0);
      @(negedge clk);
      chk("t2_nfull", int'(o0_nearly_full), int'(i >= 6));
      chk("t2_full", int'(o0_full), int'(i == 7));
    end
    step(0, 1, 16'h00AA, 0, 0, 0);
    @(negedge clk);
    chk("t2_overflow", int'(o0_overflow), 1);
    chk("t2_count", int'(o0_count), 8);
    for (int i = 0; i < D; i++) begin
      chk("t2_rd_dout", int'(o0_dout), i);
      step(0, 0, '0, 0, 0, 1);
      @(negedge clk);
    end
    chk("t2_drained", int'(o0_empty), 1);

    // 3: steady count 4 with simultaneous write+read across the wrap
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, W'(16'h3000 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, W'(16'h3100 + i), 0, 0, 1);
      @(negedge clk);
      chk("t3_count", int'(o0_count), 4);
    end

    // 4: underflow, then reset clears it
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1);
    @(negedge clk);
    chk("t4_underflow", int'(o0_underflow), 1);
    chk("t4_count", int'(o0_count), 0);
    step(1, 0, '0, 0, 0, 0);
    @(negedge clk);
    chk("t4_udf_cleared", int'(o0_underflow), 0);
    chk("t4_empty", int'(o0_empty), 1);

    // 5: commit mode - pending words, commit, drop
    step(0, 1, 16'hA000, 0, 0, 0);
    step(0, 1, 16'hA001, 0, 0, 0);
    step(0, 1, 16'hA002, 0, 0, 0);
    @(negedge clk);
    chk("t5_used3", int'(o1_used), 3);
    chk("t5_count0", int'(o1_count), 0);
    chk("t5_empty", int'(o1_empty), 1);
    step(0, 1, 16'hA003, 1, 0, 0);
    @(negedge clk);
    chk("t5_count4", int'(o1_count), 4);
    chk("t5_dout", int'(o1_dout), 'hA000);
    step(0, 1, 16'hB000, 0, 0, 0);
    step(0, 1, 16'hB001, 0, 0, 0);
    step(0, 1, 16'hB002, 0, 1, 0);
    @(negedge clk);
    chk("t5_used_after_drop", int'(o1_used), 4);
    chk("t5_count_after_drop", int'(o1_count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_rd_dout", int'(o1_dout), 'hA000 + i);
      step(0, 0, '0, 0, 0, 1);
      @(negedge clk);
    end
    chk("t5_empty_end", int'(o1_empty), 1);

    // 6: full of pending words, then drop everything
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < D; i++) step(0, 1, W'(16'h6000 + i), 0, 0, 0);
    @(negedge clk);
    chk("t6_full", int'(o1_full), 1);
    chk("t6_empty", int'(o1_empty), 1);
    step(0, 0, '0, 0, 1, 0);
    @(negedge clk);
    chk("t6_used0", int'(o1_used), 0);
    chk("t6_full0", int'(o1_full), 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 60,
           W'($urandom),
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 45);
    end
    step(0, 0, '0, 0, 0, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
